// File: rtl/bcnn_pkg.sv
// Shared widths, host-word field offsets and FSM states for the BCNN host stream interface.
package bcnn_pkg;
  localparam int DATA_W     = 9;
  localparam int BIAS_W     = 4;
  localparam int WORD_W     = 22;
  localparam int ENTRY_W    = WORD_W + 1;
  localparam int PACK_W     = 8;
  localparam int DATA_LSB   = 0;
  localparam int WEIGHT_LSB = 9;
  localparam int BIAS_LSB   = 18;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
endpackage

// File: rtl/bcnn_tx_fifo.sv
// Synchronous FIFO for host words; push and pop may coincide at any occupancy, including full.
module bcnn_tx_fifo
  import bcnn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wptr_q, rptr_q;
  logic               do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // At full a push lands in the slot the simultaneous pop frees.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/bcnn_stream_if.sv
// Feeds FIFO'd host words onto the BCNN core one per clock and packs its result bits into bytes.
// state  | meaning
// IDLE   | bus zero, waiting for a queued word
// STREAM | popping one word per cycle, zero bubbles when the FIFO runs dry
// FLUSH  | LAT cycles after a frame's last word; next frame held in the FIFO
module bcnn_stream_if
  import bcnn_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic [DATA_W-1:0] bcnn_data,
  output logic [DATA_W-1:0] bcnn_weight,
  output logic [BIAS_W-1:0] bcnn_bias,
  input  logic              bcnn_out,
  output logic              m_valid,
  output logic [PACK_W-1:0] m_data,
  output logic [3:0]        m_count,
  output logic              m_last
);
  localparam int FW = $clog2(LAT + 1);
  localparam int PW = $clog2(PACK_W);

  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] head;

  state_t             state_q, state_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic [DATA_W-1:0]  data_q, data_d, weight_q, weight_d;
  logic [BIAS_W-1:0]  bias_q, bias_d;
  logic               tag_d, tlast_d;
  logic [LAT-1:0]     tag_q, tlast_q;

  logic [PACK_W-1:0]  pack_q, pack_d, pack_bits, mdata_q, mdata_d;
  logic [3:0]         cnt_q, cnt_d, cnt_n, mcount_q, mcount_d;
  logic               mvalid_q, mvalid_d, mlast_q, mlast_d;

  assign s_ready = !full && !reset_in;
  assign push    = s_valid && s_ready;

  bcnn_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({s_last, s_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    pop      = 1'b0;
    data_d   = '0;
    weight_d = '0;
    bias_d   = '0;
    tag_d    = 1'b0;
    tlast_d  = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = STREAM;
      STREAM: begin
        if (!empty) begin
          pop      = 1'b1;
          data_d   = head[DATA_LSB +: DATA_W];
          weight_d = head[WEIGHT_LSB +: DATA_W];
          bias_d   = head[BIAS_LSB +: BIAS_W];
          tag_d    = 1'b1;
          tlast_d  = head[WORD_W];
          if (head[WORD_W]) begin
            state_d = FLUSH;
            flush_d = FW'(LAT - 1);
          end
        end
      end
      FLUSH: begin
        if (flush_q == '0) state_d = IDLE;
        else               flush_d = flush_q - FW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag at the last pipeline stage lines up with the core result on bcnn_out.
  always_comb begin
    pack_d    = pack_q;
    cnt_d     = cnt_q;
    pack_bits = pack_q;
    cnt_n     = cnt_q + 4'd1;
    mvalid_d  = 1'b0;
    mdata_d   = '0;
    mcount_d  = '0;
    mlast_d   = 1'b0;
    if (tag_q[LAT-1]) begin
      pack_bits[cnt_q[PW-1:0]] = bcnn_out;
      if (cnt_n == 4'(PACK_W) || tlast_q[LAT-1]) begin
        mvalid_d = 1'b1;
        mdata_d  = pack_bits;
        mcount_d = cnt_n;
        mlast_d  = tlast_q[LAT-1];
        pack_d   = '0;
        cnt_d    = '0;
      end else begin
        pack_d = pack_bits;
        cnt_d  = cnt_n;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      flush_q  <= '0;
      data_q   <= '0;
      weight_q <= '0;
      bias_q   <= '0;
      tag_q    <= '0;
      tlast_q  <= '0;
      pack_q   <= '0;
      cnt_q    <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mcount_q <= '0;
      mlast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      data_q     <= data_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
      tag_q[0]   <= tag_d;
      tlast_q[0] <= tlast_d;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i]   <= tag_q[i-1];
        tlast_q[i] <= tlast_q[i-1];
      end
      pack_q   <= pack_d;
      cnt_q    <= cnt_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mcount_q <= mcount_d;
      mlast_q  <= mlast_d;
    end
  end

  assign bcnn_data   = data_q;
  assign bcnn_weight = weight_q;
  assign bcnn_bias   = bias_q;
  assign m_valid     = mvalid_q;
  assign m_data      = mdata_q;
  assign m_count     = mcount_q;
  assign m_last      = mlast_q;
endmodule

// File: tb/tb_bcnn_stream_if.sv
// Directed bench for bcnn_stream_if with a LAT-cycle core model and result/bus monitors.
module tb_bcnn_stream_if;
  import bcnn_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        s_valid;
  logic        s_ready;
  logic [21:0] s_data;
  logic        s_last;
  logic [8:0]  bcnn_data, bcnn_weight;
  logic [3:0]  bcnn_bias;
  logic        bcnn_out = 1'b0;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [3:0]  m_count;
  logic        m_last;

  bcnn_stream_if #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk_in     (clk),
    .reset_in   (reset_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .bcnn_data  (bcnn_data),
    .bcnn_weight(bcnn_weight),
    .bcnn_bias  (bcnn_bias),
    .bcnn_out   (bcnn_out),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_count    (m_count),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  // Core model: each nonzero word on the bus consumes the next pattern bit; idle/bubble cycles
  // answer 1 so that a wrongly packed bubble shows up in the byte.
  logic [511:0]   pat;
  int             widx = 0;
  logic [LAT-1:0] dl = '0;
  always @(posedge clk) begin
    logic b;
    #2;
    b = 1'b1;
    if ({bcnn_bias, bcnn_weight, bcnn_data} != 22'd0) begin
      b = pat[widx];
      widx++;
    end
    dl = {dl[LAT-2:0], b};
    bcnn_out = dl[LAT-1];
  end

  logic [7:0]  mq_data[$];
  logic [3:0]  mq_cnt[$];
  logic        mq_last[$];
  logic [21:0] bq[$];
  always @(negedge clk) begin
    if (m_valid) begin
      mq_data.push_back(m_data);
      mq_cnt.push_back(m_count);
      mq_last.push_back(m_last);
    end
    bq.push_back({bcnn_bias, bcnn_weight, bcnn_data});
  end

  int checks = 0;
  int errors = 0;
  int mrd    = 0;
  int rej;
  int base;
  int mark;
  int nzp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] wd(input logic [8:0] d, input logic [8:0] w, input logic [3:0] b);
    return {b, w, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) step();
  endtask

  // Presents one word and returns once it is accepted; rej = cycles refused.
  task automatic send(input logic [21:0] w, input logic l);
    logic ok;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = l;
    rej     = 0;
    forever begin
      ok = s_ready;
      step();
      if (ok) break;
      rej++;
      if (rej > 50) begin
        check("send_timeout", 32'(rej), 32'd0);
        break;
      end
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic [3:0] c, input logic l);
    int n = 0;
    while (mq_data.size() <= mrd && n < 80) begin
      step();
      n++;
    end
    check({tag, "_present"}, 32'(mq_data.size() > mrd), 32'd1);
    if (mq_data.size() > mrd) begin
      check({tag, "_data"},  32'(mq_data[mrd]), 32'(d));
      check({tag, "_count"}, 32'(mq_cnt[mrd]),  32'(c));
      check({tag, "_last"},  32'(mq_last[mrd]), 32'(l));
      mrd++;
    end
  endtask

  task automatic scan(input int from);
    nzp.delete();
    for (int i = from; i < bq.size(); i++)
      if (bq[i] != 22'd0) nzp.push_back(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [21:0] w;
    reset_in = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    pat      = '0;

    step();
    step();
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_bus",   32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'd0);
    check("rst_m",     32'({m_valid, m_data, m_count, m_last}), 32'd0);
    reset_in = 1'b0;
    step();
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // 3-word frame: two-cycle latency, then three back-to-back words
    base = widx;
    pat[base] = 1'b1; pat[base+1] = 1'b0; pat[base+2] = 1'b1;
    w = wd(9'h1FF, 9'h1FF, 4'h3);
    send(w, 1'b0);
    send(w, 1'b0);
    check("t1_latency", 32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'd0);
    send(w, 1'b1);
    check("t1_w1", 32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'(w));
    s_valid = 1'b0;
    step();
    check("t1_w2", 32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'(w));
    step();
    check("t1_w3", 32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'(w));
    step();
    check("t1_after", 32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'd0);
    expect_byte("t1", 8'h05, 4'd3, 1'b1);
    idle(12);
    check("t1_single", 32'(mq_data.size()), 32'(mrd));

    // 16-word frame, alternating results: two full bytes, only the second marked last
    base = widx;
    for (int i = 0; i < 16; i++) pat[base+i] = (i % 2 == 0);
    for (int i = 0; i < 16; i++) send(wd(9'(i + 1), 9'h00A, 4'h1), i == 15);
    s_valid = 1'b0;
    expect_byte("t2a", 8'h55, 4'd8, 1'b0);
    expect_byte("t2b", 8'h55, 4'd8, 1'b1);
    idle(12);
    check("t2_no_extra", 32'(mq_data.size()), 32'(mrd));

    // Host gap after word 2; the FIFO hides one idle host cycle, leaving two bubbles
    base = widx;
    pat[base] = 1'b1; pat[base+1] = 1'b1; pat[base+2] = 1'b0; pat[base+3] = 1'b1; pat[base+4] = 1'b0;
    mark = bq.size();
    send(wd(9'h101, 9'h055, 4'h2), 1'b0);
    send(wd(9'h102, 9'h055, 4'h2), 1'b0);
    idle(3);
    send(wd(9'h103, 9'h055, 4'h2), 1'b0);
    send(wd(9'h104, 9'h055, 4'h2), 1'b0);
    send(wd(9'h105, 9'h055, 4'h2), 1'b1);
    s_valid = 1'b0;
    expect_byte("t3", 8'h0B, 4'd5, 1'b1);
    scan(mark);
    check("t3_words", 32'(nzp.size()), 32'd5);
    if (nzp.size() == 5) begin
      check("t3_bubbles", 32'(nzp[2] - nzp[1] - 1), 32'd2);
      for (int k = 0; k < 5; k++)
        check("t3_order", 32'(bq[nzp[k]]), 32'(wd(9'(9'h101 + k), 9'h055, 4'h2)));
    end
    idle(10);

    // One-word frame then a six-word frame: FIFO fills during the LAT-cycle flush
    base = widx;
    pat[base] = 1'b1;
    pat[base+1] = 1'b0; pat[base+2] = 1'b1; pat[base+3] = 1'b1;
    pat[base+4] = 1'b0; pat[base+5] = 1'b0; pat[base+6] = 1'b1;
    mark = bq.size();
    send(wd(9'h0AA, 9'h001, 4'h5), 1'b1);
    begin
      int acc_rej = 0;
      for (int i = 0; i < 4; i++) begin
        send(wd(9'(9'h0B0 + i), 9'h002, 4'h6), 1'b0);
        acc_rej += rej;
      end
      check("t4_accept4", 32'(acc_rej), 32'd0);
    end
    check("t4_full", 32'(s_ready), 32'd0);
    send(wd(9'h0B4, 9'h002, 4'h6), 1'b0);
    check("t4_stall", 32'(rej), 32'd4);
    send(wd(9'h0B5, 9'h002, 4'h6), 1'b1);
    check("t4_resume", 32'(rej), 32'd0);
    s_valid = 1'b0;
    expect_byte("t4a", 8'h01, 4'd1, 1'b1);
    expect_byte("t4b", 8'h26, 4'd6, 1'b1);
    scan(mark);
    check("t4_words", 32'(nzp.size()), 32'd7);
    if (nzp.size() == 7) begin
      check("t4_gap", 32'(nzp[1] - nzp[0] - 1), 32'(LAT + 1));
      for (int k = 0; k < 6; k++)
        check("t4_order", 32'(bq[nzp[k+1]]), 32'(wd(9'(9'h0B0 + k), 9'h002, 4'h6)));
    end
    idle(10);

    // Two-word frame immediately followed by a one-word frame
    base = widx;
    pat[base] = 1'b1; pat[base+1] = 1'b1; pat[base+2] = 1'b0;
    mark = bq.size();
    send(wd(9'h011, 9'h0F0, 4'h7), 1'b0);
    send(wd(9'h012, 9'h0F0, 4'h7), 1'b1);
    send(wd(9'h021, 9'h0F1, 4'h8), 1'b1);
    s_valid = 1'b0;
    expect_byte("t5a", 8'h03, 4'd2, 1'b1);
    expect_byte("t5b", 8'h00, 4'd1, 1'b1);
    scan(mark);
    check("t5_words", 32'(nzp.size()), 32'd3);
    if (nzp.size() == 3) check("t5_gap", 32'(nzp[2] - nzp[1] - 1), 32'(LAT + 1));
    idle(10);

    // Reset after five words of a longer frame; queued words and the partial byte vanish
    base = widx;
    for (int i = 0; i < 8; i++) pat[base+i] = 1'b1;
    mark = bq.size();
    for (int i = 0; i < 7; i++) send(wd(9'(9'h040 + i), 9'h003, 4'h9), 1'b0);
    s_valid  = 1'b0;
    reset_in = 1'b1;
    step();
    check("t6_rst_ready", 32'(s_ready), 32'd0);
    check("t6_rst_bus",   32'({bcnn_bias, bcnn_weight, bcnn_data}), 32'd0);
    check("t6_rst_m",     32'({m_valid, m_data, m_count, m_last}), 32'd0);
    reset_in = 1'b0;
    idle(12);
    check("t6_no_partial", 32'(mq_data.size()), 32'(mrd));
    scan(mark);
    check("t6_driven", 32'(nzp.size()), 32'd5);
    base = widx;
    pat[base] = 1'b0; pat[base+1] = 1'b1; pat[base+2] = 1'b1;
    send(wd(9'h061, 9'h004, 4'hA), 1'b0);
    send(wd(9'h062, 9'h004, 4'hA), 1'b0);
    send(wd(9'h063, 9'h004, 4'hA), 1'b1);
    s_valid = 1'b0;
    expect_byte("t6_new", 8'h06, 4'd3, 1'b1);
    idle(12);
    check("t6_single", 32'(mq_data.size()), 32'(mrd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
